// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU execution unit.
// Optional feature macro used by this slice: ALU_FAST_SHIFT_EN.
package alu_pkg;

  localparam int ALU_DATA_W  = 32;
  localparam int ALU_SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_ILL8 = 4'b1000,
    OP_EQ   = 4'b1001,
    OP_NE   = 4'b1010,
    OP_SLT  = 4'b1011,
    OP_GE   = 4'b1100,
    OP_LUI  = 4'b1101,
    OP_ILLE = 4'b1110,
    OP_ILLF = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational evaluation of all non-shift opcodes plus illegal-op decode.
// Shift opcodes pass operand A through (the zero-amount result).
module alu_comb_core
  import alu_pkg::*;
(
  input  alu_op_e               op,
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  output logic [ALU_DATA_W-1:0] res,
  output logic                  illegal
);

  localparam logic [ALU_DATA_W-2:0] ZPAD = '0;

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_SRL, OP_SRA, OP_SLL: res = a;
      OP_EQ:  res = {ZPAD, (a == b)};
      OP_NE:  res = {ZPAD, (a != b)};
      OP_SLT: res = {ZPAD, ($signed(a) <  $signed(b))};
      OP_GE:  res = {ZPAD, ($signed(a) >= $signed(b))};
      OP_LUI: res = b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execution unit with valid/ready handshakes on both sides.
// ALU_FAST_SHIFT_EN: barrel shifter in IDLE instead of the 1-bit/cycle shifter.
module alu_seq_exec
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [ALU_DATA_W-1:0] SrcA,
  input  logic [ALU_DATA_W-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_DATA_W-1:0] ALUResult,
  output logic                  Illegal
);

  alu_state_e             state, state_nxt;
  alu_op_e                op_in;
  logic [ALU_SHAMT_W-1:0] shamt_in;
  logic [ALU_DATA_W-1:0]  core_res, res_q;
  logic                   core_ill, ill_q;

  assign op_in    = alu_op_e'(Operation);
  assign shamt_in = SrcB[ALU_SHAMT_W-1:0];

  alu_comb_core u_core (
    .op      (op_in),
    .a       (SrcA),
    .b       (SrcB),
    .res     (core_res),
    .illegal (core_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    ALUResult = res_q;
    Illegal   = ill_q;
  end

`ifdef ALU_FAST_SHIFT_EN
  logic [ALU_DATA_W-1:0] barrel;

  always_comb begin
    barrel = core_res;
    case (op_in)
      OP_SRL:  barrel = SrcA >> shamt_in;
      OP_SRA:  barrel = ALU_DATA_W'($signed(SrcA) >>> shamt_in);
      OP_SLL:  barrel = SrcA << shamt_in;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      res_q <= barrel;
      ill_q <= core_ill;
    end
  end
`else
  logic [ALU_DATA_W-1:0]  work_q, shift_one;
  logic [ALU_SHAMT_W-1:0] cnt_q;
  alu_op_e                sop_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (in_valid)
          state_nxt = (is_shift(op_in) && shamt_in != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt_q == ALU_SHAMT_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)                state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_one = work_q;
    case (sop_q)
      OP_SRL:  shift_one = {1'b0, work_q[ALU_DATA_W-1:1]};
      OP_SRA:  shift_one = {work_q[ALU_DATA_W-1], work_q[ALU_DATA_W-1:1]};
      OP_SLL:  shift_one = {work_q[ALU_DATA_W-2:0], 1'b0};
      default: ;
    endcase
  end

  // res_q is loaded on accept for every op; for a multi-cycle shift it is
  // overwritten by the final shift before DONE, so out_valid never sees it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= '0;
      ill_q  <= 1'b0;
      work_q <= '0;
      cnt_q  <= '0;
      sop_q  <= OP_AND;
    end else begin
      case (state)
        ST_IDLE:
          if (in_valid) begin
            res_q  <= core_res;
            ill_q  <= core_ill;
            work_q <= SrcA;
            cnt_q  <= shamt_in;
            sop_q  <= op_in;
          end
        ST_SHIFT: begin
          work_q <= shift_one;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == ALU_SHAMT_W'(1)) res_q <= shift_one;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execution unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two 32-bit operands, and returns a registered 32-bit result. It sits between the decode stage and writeback/branch resolution, with valid/ready handshakes on both sides. Shift operations run through an iterative 1-bit-per-cycle shifter unless the fast-shift option is compiled in.

## Interface
- No parameters; data width fixed at 32, operation code width fixed at 4.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `Operation` in 4: operation code, sampled on accept.
- `SrcA` in 32: operand A, sampled on accept.
- `SrcB` in 32: operand B (or immediate), sampled on accept.
- `out_valid` out 1: `ALUResult`/`Illegal` valid.
- `out_ready` in 1: consumer accepts the result.
- `ALUResult` out 32: registered result.
- `Illegal` out 1: operation code was unsupported; registered with the result.

## Operation
- Opcode map:
  - 0000 AND; 0001 OR; 0010 XOR; 0011 ADD; 0100 SUB.
  - 0101 SRL, 0110 SRA, 0111 SLL: shift amount is `SrcB[4:0]`.
  - 1001 EQ, 1010 NE, 1011 SLT (signed), 1100 GE (signed): result is {31'b0, cond}.
  - 1101 LUI: result = `SrcB`.
  - 1000, 1110, 1111: result 0, `Illegal`=1.
- Arithmetic: ADD/SUB wrap modulo 2^32, no carry/overflow output. SRA replicates `SrcA[31]`.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch operands and opcode.
    - Non-shift ops, or shift with amount 0: go to DONE.
    - Shift with amount > 0: go to SHIFT.
  - SHIFT: each cycle shift the working register one bit in the latched direction and decrement the counter. When the counter reaches 1, the final shift is performed and the FSM goes to DONE.
  - DONE: `out_valid`=1; `ALUResult` and `Illegal` held stable. When `out_ready`=1, go to IDLE.
- `in_ready` is 0 outside IDLE. Input changes while not in IDLE are ignored.
- `out_valid` never drops without a handshake. Outputs do not change while `out_valid`=1 and `out_ready`=0.
- Reset (`rst_n`=0 at an edge), including mid-SHIFT or mid-DONE: FSM to IDLE, pending operation discarded.
- Reset values: `in_ready`=1 (first cycle after reset), `out_valid`=0, `ALUResult`=0, `Illegal`=0.

## Timing
- Request accepted at edge T (in_valid && in_ready).
- Non-shift op: `out_valid`=1 from the cycle after T. Latency is 1 cycle.
- Shift op with amount n: `out_valid` rises at T+1+n. Latency ranges from 1 (n=0) to 32 (n=31).
- Result accepted at edge R (out_valid && out_ready). `in_ready`=1 from R+1.
- Best-case throughput: 1 operation per 2 cycles. There is no accept in the same cycle as a result handshake.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts are computed combinationally in IDLE with a barrel shifter and go directly to DONE. All operations have 1-cycle latency.
  - SHIFT state and shift counter are not built.
- `ALU_FAST_SHIFT_EN` undefined: the iterative shifter described above is used.

## Structure
- Package `alu_pkg`:
  - `alu_op_e`: 4-bit enum with the opcode map above.
  - `alu_state_e`: IDLE/SHIFT/DONE.
  - Constants `ALU_DATA_W`=32 and `ALU_SHAMT_W`=5.
- Sub-module `alu_comb_core`: purely combinational evaluation of all non-shift opcodes plus the `Illegal` decode, instantiated once. The FSM, shift counter and output registers live in `alu_seq_exec`.

## Test plan
- Reset mid-SHIFT: SLL, A=1, B=20; assert `rst_n`=0 at the 5th SHIFT cycle -> next cycle `out_valid`=0, `ALUResult`=0, `in_ready`=1, and no stale result appears afterward.
- ADD, A=0xFFFFFFFF, B=2 -> `ALUResult`=0x00000001 one cycle after accept. Then SUB, A=0, B=1 -> 0xFFFFFFFF.
- SRA, A=0x80000000, B=31 (iterative build) -> `out_valid` exactly 32 cycles after accept, result 0xFFFFFFFF. With B=0 -> 1 cycle, result 0x80000000.
- SLT, A=0xFFFFFFFF, B=1 -> result 1. GE with the same operands -> result 0. EQ, A=B=0x1234 -> 1. NE with the same operands -> 0.
- Backpressure: LUI, B=0xABCDE000, with `out_ready`=0 for 5 cycles -> result held stable with `in_ready`=0 throughout; after `out_ready`=1, `in_ready`=1 on the next cycle.
- Illegal: `Operation`=1000 -> `ALUResult`=0, `Illegal`=1. A following AND, 0xF0F0 & 0x0FF0 -> 0x00F0 with `Illegal`=0.
